// File: rtl/if_fetch.sv
// Instruction fetch unit: owns the PC, issues one word fetch at a time on the
// request/grant/response bus and presents the result to the decode register.
module if_fetch #(
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
    parameter logic [31:0] NOP_INST   = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] jump_addr_i,
    input  logic        jump_en_i,
    input  logic        hold_flag_i,
    output logic        ibus_req_o,
    output logic [31:0] ibus_addr_o,
    input  logic        ibus_gnt_i,
    input  logic        ibus_rvalid_i,
    input  logic [31:0] ibus_rdata_i,
    output logic [31:0] inst_o,
    output logic [31:0] inst_addr_o,
    output logic        inst_valid_o
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] req_addr_q, req_addr_d;
    logic        kill_q, kill_d;
    logic [31:0] buf_data_q, buf_data_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] inst_addr_q, inst_addr_d;
    logic        inst_valid_q, inst_valid_d;
    logic [31:0] jump_tgt;

    // Masking (rather than slicing) keeps every jump address bit in use.
    assign jump_tgt = jump_addr_i & 32'hFFFF_FFFC;

    // Request is gated by reset so the bus sees no request while rst_n is low.
    assign ibus_req_o   = rst_n && (state_q == S_REQ) && !jump_en_i;
    assign ibus_addr_o  = pc_q;
    assign inst_o       = inst_q;
    assign inst_addr_o  = inst_addr_q;
    assign inst_valid_o = inst_valid_q;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        req_addr_d   = req_addr_q;
        kill_d       = kill_q;
        buf_data_d   = buf_data_q;
        inst_d       = inst_q;
        inst_addr_d  = inst_addr_q;
        inst_valid_d = inst_valid_q;

        // Decode consumes a valid instruction whenever it is not holding.
        if (inst_valid_q && !hold_flag_i) begin
            inst_d       = NOP_INST;
            inst_valid_d = 1'b0;
        end

        case (state_q)
            S_REQ: begin
                if (!jump_en_i && ibus_gnt_i) begin
                    req_addr_d = pc_q;
                    state_d    = S_WAIT;
                end
            end
            S_WAIT: begin
                if (ibus_rvalid_i) begin
                    if (kill_q) begin
                        kill_d  = 1'b0;
                        state_d = S_REQ;
                    end else if (!hold_flag_i) begin
                        inst_d       = ibus_rdata_i;
                        inst_addr_d  = req_addr_q;
                        inst_valid_d = 1'b1;
                        pc_d         = req_addr_q + 32'd4;
                        state_d      = S_REQ;
                    end else begin
                        buf_data_d = ibus_rdata_i;
                        state_d    = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (!hold_flag_i) begin
                    inst_d       = buf_data_q;
                    inst_addr_d  = req_addr_q;
                    inst_valid_d = 1'b1;
                    pc_d         = req_addr_q + 32'd4;
                    state_d      = S_REQ;
                end
            end
            default: state_d = S_REQ;
        endcase

        // A redirect overrides hold and any delivery computed above.
        if (jump_en_i) begin
            pc_d         = jump_tgt;
            inst_d       = NOP_INST;
            inst_valid_d = 1'b0;
            inst_addr_d  = inst_addr_q;
            buf_data_d   = buf_data_q;
            case (state_q)
                S_WAIT: begin
                    if (ibus_rvalid_i) begin
                        kill_d  = 1'b0;
                        state_d = S_REQ;
                    end else begin
                        kill_d  = 1'b1;
                        state_d = S_WAIT;
                    end
                end
                default: state_d = S_REQ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_REQ;
            pc_q         <= RESET_ADDR;
            req_addr_q   <= RESET_ADDR;
            kill_q       <= 1'b0;
            buf_data_q   <= 32'd0;
            inst_q       <= NOP_INST;
            inst_addr_q  <= RESET_ADDR;
            inst_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            req_addr_q   <= req_addr_d;
            kill_q       <= kill_d;
            buf_data_q   <= buf_data_d;
            inst_q       <= inst_d;
            inst_addr_q  <= inst_addr_d;
            inst_valid_q <= inst_valid_d;
        end
    end

endmodule

// File: doc/if_fetch.md
# if_fetch

Instruction fetch unit for the in-order RV32 core. It owns the program counter and fetches one word per request over a request/grant/response instruction bus. It delivers the fetched instruction and its address to the decode-stage register. It is the consumer of the pipeline control outputs: the jump address, jump enable and hold flag driven by the control block.

## Interface
- RESET_ADDR, default 32'h0000_0000: PC value after reset. Must be word-aligned.
- NOP_INST, default 32'h0000_0013: instruction driven on `inst_o` when no valid instruction is present (addi x0,x0,0).

Ports:
- clk  in  1  sole clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- jump_addr_i  in  32  redirect target from control. Bits [1:0] are ignored and treated as 0.
- jump_en_i  in  1  redirect request from control; valid for one cycle.
- hold_flag_i  in  1  pipeline hold from control; freezes the outputs.
- ibus_req_o  out  1  fetch request.
- ibus_addr_o  out  32  fetch address, equal to the PC and word-aligned.
- ibus_gnt_i  in  1  request accepted this cycle.
- ibus_rvalid_i  in  1  read data valid. Arrives one or more cycles after the grant.
- ibus_rdata_i  in  32  instruction word.
- inst_o  out  32  instruction to decode.
- inst_addr_o  out  32  address of `inst_o`.
- inst_valid_o  out  1  `inst_o` holds a real instruction.

## Operation
- Registers:
  - `pc`: 32 bits.
  - `req_addr`: address of the outstanding request.
  - `kill`: 1 bit.
  - `buf_data`: 32 bits, parking buffer.
  - `state` ∈ {S_REQ, S_WAIT, S_HOLD}.
- At most one request is outstanding at any time.
- `ibus_req_o = (state==S_REQ) && !jump_en_i`.
- `ibus_addr_o = pc`.
- S_REQ:
  - On `ibus_req_o && ibus_gnt_i`: `req_addr <= pc`, go to S_WAIT.
  - With no grant, stay in S_REQ.
- S_WAIT, on `ibus_rvalid_i`:
  - If `kill` is set: discard the data, clear `kill`, go to S_REQ.
  - Else if `hold_flag_i` is 0: `inst_o <= rdata`, `inst_addr_o <= req_addr`, `inst_valid_o <= 1`, `pc <= req_addr + 4` (mod 2^32), go to S_REQ.
  - Else (hold active): `buf_data <= rdata`, go to S_HOLD.
- S_HOLD:
  - While `hold_flag_i` is 1, stay in S_HOLD.
  - When `hold_flag_i` is 0: deliver `buf_data`/`req_addr` to the outputs exactly as the unheld case in S_WAIT does, and go to S_REQ.
- Consumption:
  - If `inst_valid_o` is 1 and `hold_flag_i` is 0 at a clock edge, decode takes the instruction.
  - Unless a new delivery occurs on that edge, the next outputs are `inst_o=NOP_INST` and `inst_valid_o=0`. `inst_addr_o` keeps its value.
- Hold: while `hold_flag_i` is 1, `inst_o`, `inst_addr_o` and `inst_valid_o` do not change, except when a jump occurs. Fetching continues while hold is active, but only up to the park buffer.
- Jump (`jump_en_i`=1) has priority over hold and over any delivery. On that edge:
  - `pc <= {jump_addr_i[31:2],2'b00}`.
  - `inst_o <= NOP_INST`, `inst_valid_o <= 0` (flush).
  - In S_WAIT without `rvalid`: set `kill`, stay in S_WAIT.
  - In S_WAIT with `rvalid`: discard the data, go to S_REQ.
  - In S_HOLD: discard `buf_data`, go to S_REQ.
  - In S_REQ: no request is issued this cycle, because `ibus_req_o` is gated; stay in S_REQ.
- A jump in the cycle after a jump simply overwrites `pc`. `kill` stays set until the stale response returns.

## Timing
- Reset values, applied asynchronously while `rst_n`=0:
  - `pc=RESET_ADDR`, `state=S_REQ`, `kill=0`, `buf_data=0`.
  - `inst_o=NOP_INST`, `inst_addr_o=RESET_ADDR`, `inst_valid_o=0`.
  - `ibus_req_o=0`, forced low while in reset.
- First request: `ibus_req_o=1` with `ibus_addr_o=RESET_ADDR` in the first cycle after `rst_n` rises.
- Reset mid-transaction: all state clears and any late `rvalid` is ignored. The bus slave must also reset on `rst_n`.
- Latency with a zero-wait bus (grant in cycle N, rvalid in N+1):
  - `inst_valid_o`=1 from cycle N+2.
  - Next request in N+2.
  - Steady-state throughput is one instruction per 2 cycles.
- Each extra `rvalid` wait cycle or ungranted request cycle adds one cycle.
- Jump to fetch: `jump_en_i` in cycle J (state S_REQ) gives a request with the target address in J+1.

## Test plan
- Reset and straight-line fetch: release reset with a zero-wait memory holding word k = 0x100+k. Required: requests to 0x0, 0x4, 0x8. `inst_o` = 0x100, 0x101, 0x102 with matching `inst_addr_o`, each valid for 1 cycle, 2 cycles apart.
- Grant stall: hold `ibus_gnt_i`=0 for 3 cycles. Required: `ibus_req_o` stays 1 with a stable `ibus_addr_o`, and no `inst_valid_o` appears early.
- Jump while waiting: pulse `jump_en_i` with `jump_addr_i`=0x203 while the fetch of 0x8 is outstanding. Required: the 0x8 response is dropped, the next request goes to 0x200, and `inst_addr_o`=0x200 follows.
- Hold with parking: assert hold for 4 cycles before `rvalid`. Required: outputs stay frozen, the response is parked, and it is delivered the cycle after hold drops. No instruction is lost or duplicated.
- Jump during S_HOLD: jump to 0x40 while an instruction is parked. Required: the buffer is discarded, `inst_valid_o`=0 next cycle, and the next request goes to 0x40.
- Reset asserted during S_WAIT: required behaviour is that all outputs return to their reset values immediately, and a late `rvalid` after `rst_n` rises does not produce `inst_valid_o`.
